// File: rtl/mr_byte_decipher_pkg.sv
// rtl/mr_byte_decipher_pkg.sv - Massey-Rueppel keystream constants, FSM encoding and generator helpers
// Shared with the transmitter so both ends step the generator identically.
//   MR_M_W / MR_L_W       widths of LFSR M and LFSR L
//   MR_M_TAPS / MR_L_TAPS feedback tap masks (feedback = parity of state & mask)
//   mr_state_e            receive FSM states
//   mr_ks_bit             keystream bit from the current generator state
//   mr_step_m / mr_step_l one shift of each LFSR
//   mr_seed_m / mr_seed_l seed with the all-zero lock-up state replaced by 1
package mr_byte_decipher_pkg;

    localparam int MR_M_W = 7;
    localparam int MR_L_W = 13;

    // M feeds back M[6]^M[5]; L feeds back L[12]^L[3]^L[2]^L[0].
    localparam logic [MR_M_W-1:0] MR_M_TAPS = 7'h60;
    localparam logic [MR_L_W-1:0] MR_L_TAPS = 13'h100D;

    typedef enum logic [1:0] {
        MR_UNSEEDED = 2'd0,
        MR_READY    = 2'd1,
        MR_GEN      = 2'd2,
        MR_HOLD     = 2'd3
    } mr_state_e;

    // Only the low MR_M_W bits of L take part in the combiner.
    function automatic logic mr_ks_bit(input logic [MR_M_W-1:0] m,
                                       input logic [MR_M_W-1:0] l_lo);
        return ^(m & l_lo);
    endfunction

    function automatic logic [MR_M_W-1:0] mr_step_m(input logic [MR_M_W-1:0] m);
        return {m[MR_M_W-2:0], ^(m & MR_M_TAPS)};
    endfunction

    function automatic logic [MR_L_W-1:0] mr_step_l(input logic [MR_L_W-1:0] l);
        return {l[MR_L_W-2:0], ^(l & MR_L_TAPS)};
    endfunction

    function automatic logic [MR_M_W-1:0] mr_seed_m(input logic [MR_M_W-1:0] seed);
        return (seed == '0) ? MR_M_W'(1) : seed;
    endfunction

    function automatic logic [MR_L_W-1:0] mr_seed_l(input logic [MR_L_W-1:0] seed);
        return (seed == '0) ? MR_L_W'(1) : seed;
    endfunction

endpackage

// File: rtl/mr_byte_decipher_ks_core.sv
// rtl/mr_byte_decipher_ks_core.sv - keystream core: LFSR M and L with seed load and step enable
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (LFSRs cleared to 0)
//   i_load                load both seeds (zero seed becomes 1); wins over i_step
//   i_seed_m, i_seed_l    seed values
//   i_step                advance both LFSRs by one position
//   o_k                   keystream bit of the current state
//   o_lfsr_m, o_lfsr_l    live LFSR states
module mr_keystream_core
    import mr_byte_decipher_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [MR_M_W-1:0] i_seed_m,
    input  logic [MR_L_W-1:0] i_seed_l,
    input  logic              i_step,
    output logic              o_k,
    output logic [MR_M_W-1:0] o_lfsr_m,
    output logic [MR_L_W-1:0] o_lfsr_l
);

    logic [MR_M_W-1:0] m_q, m_d;
    logic [MR_L_W-1:0] l_q, l_d;

    always_comb begin
        m_d = m_q;
        l_d = l_q;
        if (i_load) begin
            m_d = mr_seed_m(i_seed_m);
            l_d = mr_seed_l(i_seed_l);
        end else if (i_step) begin
            m_d = mr_step_m(m_q);
            l_d = mr_step_l(l_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            m_q <= '0;
            l_q <= '0;
        end else begin
            m_q <= m_d;
            l_q <= l_d;
        end
    end

    assign o_k      = mr_ks_bit(m_q, l_q[MR_M_W-1:0]);
    assign o_lfsr_m = m_q;
    assign o_lfsr_l = l_q;

endmodule

// File: rtl/mr_byte_decipher.sv
// rtl/mr_byte_decipher.sv - Massey-Rueppel receive decipher: ciphertext in, plaintext out
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_seed_load, i_seed_lfsrM/L   seed pulse and seeds; restarts the stream from any state
//   i_ct_valid/o_ct_ready/i_ct_data  ciphertext word handshake
//   o_pt_valid/i_pt_ready/o_pt_data  plaintext word handshake
//   o_seeded                      seeds loaded since reset
//   o_lfsrM, o_lfsrL              live generator state
module mr_byte_decipher
    import mr_byte_decipher_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_seed_load,
    input  logic [MR_M_W-1:0] i_seed_lfsrM,
    input  logic [MR_L_W-1:0] i_seed_lfsrL,
    input  logic              i_ct_valid,
    output logic              o_ct_ready,
    input  logic [DATA_W-1:0] i_ct_data,
    output logic              o_pt_valid,
    input  logic              i_pt_ready,
    output logic [DATA_W-1:0] o_pt_data,
    output logic              o_seeded,
    output logic [MR_M_W-1:0] o_lfsrM,
    output logic [MR_L_W-1:0] o_lfsrL
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mr_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              seeded_q, seeded_d;
    logic              ks_bit;
    logic              step;
    logic              accept;

    assign step   = (state_q == MR_GEN);
    assign accept = o_ct_ready & i_ct_valid;

    mr_keystream_core u_ks (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (i_seed_load),
        .i_seed_m (i_seed_lfsrM),
        .i_seed_l (i_seed_lfsrL),
        .i_step   (step),
        .o_k      (ks_bit),
        .o_lfsr_m (o_lfsrM),
        .o_lfsr_l (o_lfsrL)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= MR_UNSEEDED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_seed_load) begin
            state_d = MR_READY;
        end else begin
            case (state_q)
                MR_UNSEEDED: state_d = MR_UNSEEDED;
                MR_READY:    if (i_ct_valid) state_d = MR_GEN;
                MR_GEN:      if (cnt_q == CNT_LAST) state_d = MR_HOLD;
                MR_HOLD:     if (i_pt_ready) state_d = MR_READY;
                default:     state_d = MR_UNSEEDED;
            endcase
        end
    end

    // Ready is withdrawn during a seed load so that a same-cycle ciphertext
    // word is visibly refused rather than silently dropped.
    always_comb begin
        o_ct_ready = (state_q == MR_READY) && !i_seed_load;
        o_pt_valid = (state_q == MR_HOLD);
    end

    // The word rotates left once per keystream bit: the MSB is XORed and moved
    // to the LSB, so after DATA_W steps every bit is back in place, MSB first.
    always_comb begin
        data_d   = data_q;
        cnt_d    = cnt_q;
        seeded_d = seeded_q;
        if (i_seed_load) begin
            seeded_d = 1'b1;
            cnt_d    = '0;
        end else if (accept) begin
            data_d = i_ct_data;
            cnt_d  = '0;
        end else if (step) begin
            data_d = {data_q[DATA_W-2:0], data_q[DATA_W-1] ^ ks_bit};
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q   <= '0;
            cnt_q    <= '0;
            seeded_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            seeded_q <= seeded_d;
        end
    end

    assign o_pt_data = data_q;
    assign o_seeded  = seeded_q;

endmodule
